// File: rtl/ins_fetch.sv
// Instruction fetch stage: 16x16 instruction store loaded over a valid/ready
// port, a 4-bit program counter, and local resolution of branch and halt words.
module ins_fetch #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  LOAD_ADDR,
    input  logic [15:0] LOAD_DATA,
    input  logic        start,
    input  logic        cond,
    output logic [15:0] INS,
    output logic [3:0]  PC,
    output logic        ins_valid,
    output logic        halted
);

    // Word presented to the decoder whenever no real instruction is available;
    // opcode 3'b011 keeps the decoder from writing.
    localparam logic [15:0] NOOP_WORD = 16'h0300;
    localparam logic [2:0]  OP_BRANCH = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  pc_q;
    logic [3:0]  pc_d;
    logic [15:0] mem_q [16];

    logic [15:0] rd_word_s;
    logic [15:0] ins_s;
    logic        ins_valid_s;
    logic        is_branch_s;
    logic        load_fire_s;

    // The store only accepts words while not executing.
    assign load_ready  = (state_q != ST_RUN);
    assign load_fire_s = load_valid & load_ready & ~rst;
    assign halted      = (state_q == ST_HALT);
    assign INS         = ins_s;
    assign ins_valid   = ins_valid_s;
    assign PC          = pc_q;

    // Next-state, next-PC and the word shown to the decoder (zero-latency fetch).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_s       = NOOP_WORD;
        ins_valid_s = 1'b0;
        rd_word_s   = mem_q[pc_q];
        is_branch_s = (rd_word_s[10:8] == OP_BRANCH);
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else begin
                    state_d = state_q;
                    pc_d    = pc_q;
                end
            end
            ST_RUN: begin
                if (rd_word_s[15]) begin
                    // Halt wins over any branch encoding in the same word; PC
                    // stays on the halt word so it can be inspected.
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end else begin
                    ins_s       = rd_word_s;
                    ins_valid_s = 1'b1;
                    if (is_branch_s && cond) begin
                        pc_d = rd_word_s[7:4];
                    end else begin
                        pc_d = pc_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State and program counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Instruction store: never cleared, so a program survives a reset.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            mem_q[LOAD_ADDR] <= LOAD_DATA;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_ins_fetch;

    localparam logic [3:0] RST_PC = 4'd0;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  LOAD_ADDR = 4'd0;
    logic [15:0] LOAD_DATA = 16'h0000;
    logic        start = 1'b0;
    logic        cond = 1'b0;
    logic [15:0] INS;
    logic [3:0]  PC;
    logic        ins_valid;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] m_mem [16];
    int          m_mode = MODE_IDLE;
    int          m_pc   = 0;

    logic [15:0] prog [4];

    ins_fetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .LOAD_ADDR  (LOAD_ADDR),
        .LOAD_DATA  (LOAD_DATA),
        .start      (start),
        .cond       (cond),
        .INS        (INS),
        .PC         (PC),
        .ins_valid  (ins_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic m_fetch_ok();
        return (m_mode == MODE_RUN) && (m_mem[m_pc][15] == 1'b0);
    endfunction

    function automatic logic [15:0] m_ins();
        if (m_fetch_ok()) return m_mem[m_pc];
        else return 16'h0300;
    endfunction

    // Apply the fetch-stage rules for one rising edge.
    task automatic model_edge();
        logic [15:0] w;
        if (rst) begin
            m_mode = MODE_IDLE;
            m_pc   = int'(RST_PC);
        end else begin
            w = m_mem[m_pc];
            if (m_mode != MODE_RUN && load_valid) m_mem[LOAD_ADDR] = LOAD_DATA;
            if (m_mode == MODE_RUN) begin
                if (w[15]) m_mode = MODE_HALT;
                else if (w[10:8] == 3'b100 && cond) m_pc = int'(w[7:4]);
                else m_pc = (m_pc + 1) % 16;
            end else if (start) begin
                m_mode = MODE_RUN;
                m_pc   = int'(RST_PC);
            end
        end
    endtask

    // Check all outputs against the model mid-cycle, then advance one edge.
    task automatic tick();
        @(negedge clk);
        check_eq("ins", INS, m_ins());
        check_eq("pc", PC, 16'(m_pc));
        check_eq("ins_valid", 16'(ins_valid), 16'(m_fetch_ok()));
        check_eq("halted", 16'(halted), 16'(m_mode == MODE_HALT));
        check_eq("load_ready", 16'(load_ready), 16'(m_mode != MODE_RUN));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        LOAD_ADDR  = a;
        LOAD_DATA  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rst_cycle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        prog[0] = 16'h0001;
        prog[1] = 16'h0112;
        prog[2] = 16'h0223;
        prog[3] = 16'h0334;

        // Power-up reset for two cycles (outputs unknown before the first edge)
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        rst = 1'b0;
        check_eq("rst_pc", 16'(PC), 16'h0000);
        check_eq("rst_ins", INS, 16'h0300);
        check_eq("rst_valid", 16'(ins_valid), 16'h0000);
        check_eq("rst_halted", 16'(halted), 16'h0000);
        check_eq("rst_ready", 16'(load_ready), 16'h0001);

        // Sequential fetch of a small program
        for (int i = 0; i < 16; i++) load_word(4'(i), 16'h0001);
        for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_pc", 16'(PC), 16'(i));
            check_eq("seq_ins", INS, prog[i]);
            check_eq("seq_valid", 16'(ins_valid), 16'h0001);
            tick();
        end
        rst_cycle();

        // Branch taken, then halt at the target
        load_word(4'd2, 16'h0450);
        load_word(4'd5, 16'h8000);
        cond = 1'b1;
        pulse_start();
        tick();
        tick();
        check_eq("br_at2", 16'(PC), 16'h0002);
        tick();
        check_eq("br_taken_pc", 16'(PC), 16'h0005);
        check_eq("halt_ins", INS, 16'h0300);
        check_eq("halt_valid", 16'(ins_valid), 16'h0000);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("halt_hold_pc", 16'(PC), 16'h0005);
            check_eq("halt_flag", 16'(halted), 16'h0001);
            tick();
        end
        pulse_start();
        check_eq("restart_pc", 16'(PC), 16'h0000);
        check_eq("restart_halted", 16'(halted), 16'h0000);
        // Branch not taken
        cond = 1'b0;
        tick();
        tick();
        check_eq("nbr_at2", 16'(PC), 16'h0002);
        tick();
        check_eq("br_not_taken_pc", 16'(PC), 16'h0003);
        tick();
        tick();
        tick();
        check_eq("halt2_flag", 16'(halted), 16'h0001);

        // Wrap-around with loads ignored while running
        for (int i = 0; i < 16; i++) load_word(4'(i), 16'h0001);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            check_eq("wrap_pc", 16'(PC), 16'(i % 16));
            check_eq("wrap_ins", INS, 16'h0001);
            if (i >= 5 && i <= 8) begin
                load_valid = 1'b1;
                LOAD_ADDR  = 4'd7;
                LOAD_DATA  = 16'h8000;
                check_eq("run_ready", 16'(load_ready), 16'h0000);
            end else begin
                load_valid = 1'b0;
            end
            tick();
        end
        load_valid = 1'b0;

        // Reset mid-run; store retained; load during reset is dropped
        rst_cycle();
        for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
        pulse_start();
        tick();
        tick();
        tick();
        check_eq("pre_rst_pc", 16'(PC), 16'h0003);
        rst        = 1'b1;
        load_valid = 1'b1;
        LOAD_ADDR  = 4'd0;
        LOAD_DATA  = 16'h8000;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        check_eq("mid_rst_pc", 16'(PC), 16'h0000);
        check_eq("mid_rst_valid", 16'(ins_valid), 16'h0000);
        check_eq("mid_rst_ins", INS, 16'h0300);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check_eq("retain_ins", INS, prog[i]);
            tick();
        end

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(7) != 0) d[15] = 1'b0;
            if ($urandom_range(2) == 0) d[10:8] = 3'b100;
            rst        = ($urandom_range(63) == 0);
            start      = ($urandom_range(7) == 0);
            cond       = 1'($urandom);
            load_valid = 1'($urandom);
            LOAD_ADDR  = 4'($urandom);
            LOAD_DATA  = d;
            tick();
        end
        rst        = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
